// File: rtl/burst_ram_pkg.sv
// rtl/burst_ram_pkg.sv - shared widths, command encodings and sequencer states for the PSRAM burst arbiter
package burst_ram_pkg;

    localparam int BR_ADDR_W = 21;
    localparam int BR_DATA_W = 64;
    localparam int BR_MASK_W = 8;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ,
        ST_GAP
    } br_state_e;

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// rtl/burst_ram_arbiter_if.sv - one requester port of the burst arbiter (request, write beats, read beats, completion)
interface burst_ram_arbiter_if #(
    parameter int BEAT_W = 2
);
    import burst_ram_pkg::*;

    logic                 req;
    logic                 cmd;
    logic [BR_ADDR_W-1:0] addr;
    logic [BR_DATA_W-1:0] wr_data;
    logic [BEAT_W-1:0]    beat;
    logic [BR_DATA_W-1:0] rd_data;
    logic                 rd_valid;
    logic                 done;
    logic                 error;

    modport master (
        output req, cmd, addr, wr_data,
        input  beat, rd_data, rd_valid, done, error
    );

    modport slave (
        input  req, cmd, addr, wr_data,
        output beat, rd_data, rd_valid, done, error
    );

endinterface

// File: rtl/burst_ram_arbiter.sv
// rtl/burst_ram_arbiter.sv - two-port round-robin arbiter and whole-burst sequencer for the PSRAM burst port
module burst_ram_arbiter
    import burst_ram_pkg::*;
#(
    parameter int BurstBeats        = 4,
    parameter int CmdIntervalCycles = 18,
    parameter int ReadTimeoutCycles = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    burst_ram_arbiter_if.slave    m0,
    burst_ram_arbiter_if.slave    m1,
    output logic                  br_cmd,
    output logic                  br_cmd_en,
    output logic [BR_ADDR_W-1:0]  br_addr,
    output logic [BR_DATA_W-1:0]  br_wr_data,
    output logic [BR_MASK_W-1:0]  br_data_mask,
    input  logic [BR_DATA_W-1:0]  br_rd_data,
    input  logic                  br_rd_data_valid
);

    localparam int BEAT_W = $clog2(BurstBeats);
    localparam int IVL_W  = $clog2(CmdIntervalCycles + 1);
    localparam int TMO_W  = $clog2(ReadTimeoutCycles + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BurstBeats - 1);
    localparam logic [IVL_W-1:0]  IVL_LOAD  = IVL_W'(CmdIntervalCycles - 1);
    localparam logic [TMO_W-1:0]  TMO_PRE   = TMO_W'(ReadTimeoutCycles - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ReadTimeoutCycles);

    br_state_e            state_q, state_d;
    logic                 owner_q;
    logic                 last_grant_q;
    logic                 cmd_q;
    logic [BR_ADDR_W-1:0] addr_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [IVL_W-1:0]     ivl_q;
    logic [TMO_W-1:0]     tmo_q;
    logic                 wr_active_q;
    logic [BR_DATA_W-1:0] rd_data_q;
    logic                 rd_valid_q;
    logic                 done_q;
    logic                 error_q;

    logic grant, grant_port, rd_take, rd_last, wr_last, tmo_hit, done_d;

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_port = owner_q;
        rd_take    = (state_q == ST_READ) && br_rd_data_valid;
        rd_last    = rd_take && (beat_q == LAST_BEAT);
        wr_last    = (state_q == ST_WRITE) && (beat_q == LAST_BEAT);
        // A final beat arriving on the timeout cycle still counts as a clean completion
        tmo_hit    = (state_q == ST_READ) && !rd_last && (tmo_q == TMO_PRE);
        done_d     = rd_last || wr_last || tmo_hit;

        case (state_q)
            ST_IDLE: begin
                if ((ivl_q == '0) && (m0.req || m1.req)) begin
                    grant      = 1'b1;
                    grant_port = (m0.req && m1.req) ? ~last_grant_q : m1.req;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD:   state_d = (cmd_q == BR_CMD_WRITE) ? ST_WRITE : ST_READ;
            ST_WRITE: if (wr_last) state_d = ST_GAP;
            ST_READ:  if (rd_last || tmo_hit) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_q        <= 1'b0;
            addr_q       <= '0;
            beat_q       <= '0;
            ivl_q        <= '0;
            tmo_q        <= '0;
            wr_active_q  <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            br_cmd_en    <= 1'b0;
        end else begin
            state_q    <= state_d;
            br_cmd_en  <= grant;
            rd_valid_q <= rd_take;
            done_q     <= done_d;
            error_q    <= tmo_hit;
            if (rd_take) rd_data_q <= br_rd_data;
            if (ivl_q != '0) ivl_q <= ivl_q - 1'b1;

            if (grant) begin
                owner_q      <= grant_port;
                last_grant_q <= grant_port;
                cmd_q        <= grant_port ? m1.cmd : m0.cmd;
                addr_q       <= grant_port ? m1.addr : m0.addr;
                wr_active_q  <= grant_port ? m1.cmd : m0.cmd;
                beat_q       <= '0;
                tmo_q        <= '0;
                ivl_q        <= IVL_LOAD;
            end else begin
                case (state_q)
                    ST_CMD: begin
                        if (cmd_q == BR_CMD_WRITE) beat_q <= beat_q + 1'b1;
                        tmo_q <= tmo_q + 1'b1;
                    end
                    ST_WRITE: begin
                        if (wr_last) wr_active_q <= 1'b0;
                        else         beat_q      <= beat_q + 1'b1;
                    end
                    ST_READ: begin
                        if (rd_take && !rd_last) beat_q <= beat_q + 1'b1;
                        if (tmo_q != TMO_MAX)    tmo_q  <= tmo_q + 1'b1;
                    end
                    ST_GAP:  beat_q <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign br_cmd       = cmd_q;
    assign br_addr      = addr_q;
    assign br_data_mask = '0;
    // Beat index is registered, so only the requester's data path is combinational here
    assign br_wr_data   = !wr_active_q ? '0 : (owner_q ? m1.wr_data : m0.wr_data);

    always_comb begin
        m0.beat     = '0;
        m0.rd_data  = '0;
        m0.rd_valid = 1'b0;
        m0.done     = 1'b0;
        m0.error    = 1'b0;
        m1.beat     = '0;
        m1.rd_data  = '0;
        m1.rd_valid = 1'b0;
        m1.done     = 1'b0;
        m1.error    = 1'b0;
        if (owner_q) begin
            m1.beat     = wr_active_q ? beat_q : '0;
            m1.rd_data  = rd_data_q;
            m1.rd_valid = rd_valid_q;
            m1.done     = done_q;
            m1.error    = error_q;
        end else begin
            m0.beat     = wr_active_q ? beat_q : '0;
            m0.rd_data  = rd_data_q;
            m0.rd_valid = rd_valid_q;
            m0.done     = done_q;
            m0.error    = error_q;
        end
    end

endmodule
